// File: rtl/adrs_dec_mmio_if.sv
// adrs_dec_mmio_if: CPU-side bus between the PICO16a core and the MMIO address decoder
interface adrs_dec_mmio_if #(
    parameter int NCH = 4
);
    logic [15:0]    adrs;
    logic           we;
    logic           err_clr;
    logic [NCH-1:0] cs;
    logic [NCH-1:0] read_stb;
    logic           rd_ack;
    logic [NCH-1:0] wr_stb;
    logic           bad_adrs;
    modport master (
        output adrs, we, err_clr,
        input  cs, read_stb, rd_ack, wr_stb, bad_adrs
    );
    modport slave (
        input  adrs, we, err_clr,
        output cs, read_stb, rd_ack, wr_stb, bad_adrs
    );
endinterface

// File: rtl/adrs_dec_mmio.sv
// adrs_dec_mmio: MMIO window decoder with one-shot read strobes, wait states, write strobes and a sticky bad-address flag
module adrs_dec_mmio #(
    parameter logic [15:0] BASE    = 16'h8008,
    parameter int          SPACE   = 2,
    parameter int          NCH     = 4,
    parameter int          RD_WAIT = 0
) (
    input logic            cpu_clk,
    input logic            rst,
    adrs_dec_mmio_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;
    localparam logic [3:0]     WAIT_CNT = 4'(RD_WAIT);
    localparam logic [SPACE:0] NCH_W    = (SPACE + 1)'(NCH);
    state_t           state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic [SPACE-1:0] idx, idx_n;
    logic [SPACE-1:0] off;
    logic [NCH-1:0]   cs, read_stb, wr_stb;
    logic             ms, req, start, bad_hit, rd_ack, bad_adrs;
    assign ms      = bus.adrs[15:SPACE] == BASE[15:SPACE];
    assign off     = bus.adrs[SPACE-1:0];
    assign req     = |cs && !bus.we;
    assign bad_hit = ms && {1'b0, off} >= NCH_W;
    // one-hot select, only mapped offsets get a bit
    always_comb begin
        cs = '0;
        for (int i = 0; i < NCH; i++) cs[i] = ms && off == SPACE'(i);
    end
    // read FSM: a new channel (re)starts the wait, a persisting read parks in HOLD
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        start   = 1'b0;
        case (state)
            IDLE: start = req;
            WAIT: begin
                if (!req || off != idx) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                    if (cnt == 4'd1) state_n = DONE;
                end
            end
            DONE, HOLD: begin
                if (!req) state_n = IDLE;
                else if (off != idx) start = 1'b1;
                else state_n = HOLD;
            end
            default: state_n = IDLE;
        endcase
        if (start) begin
            idx_n   = off;
            cnt_n   = WAIT_CNT;
            state_n = RD_WAIT == 0 ? DONE : WAIT;
        end
    end
    // FSM state, captured channel and wait counter
    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end
    // registered strobes: read pulse on entry to DONE, write level one cycle behind the bus, sticky error with set priority
    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            read_stb <= '0;
            rd_ack   <= 1'b0;
            wr_stb   <= '0;
            bad_adrs <= 1'b0;
        end else begin
            read_stb <= state_n == DONE ? NCH'(1) << idx_n : '0;
            rd_ack   <= state_n == DONE;
            wr_stb   <= cs & {NCH{bus.we}};
            bad_adrs <= bad_hit || (bad_adrs && !bus.err_clr);
        end
    end
    assign bus.cs       = cs;
    assign bus.read_stb = read_stb;
    assign bus.rd_ack   = rd_ack;
    assign bus.wr_stb   = wr_stb;
    assign bus.bad_adrs = bad_adrs;
endmodule

// File: tb/tb_adrs_dec_mmio.sv
// tb_adrs_dec_mmio: scoreboard bench driving three decoder configurations from one shared CPU bus
module tb_adrs_dec_mmio;
    localparam int NI = 3;
    localparam int WS [NI] = '{0, 3, 5};
    localparam int NS [NI] = '{4, 4, 3};
    typedef struct {
        int         cyc;
        logic [3:0] stb;
    } ev_t;
    logic        cpu_clk = 1'b0;
    logic        rst     = 1'b1;
    logic [15:0] adrs    = '0;
    logic        we      = 1'b0;
    logic        err_clr = 1'b0;
    int          n_cmp   = 0;
    int          n_bad   = 0;
    always #5 cpu_clk = ~cpu_clk;
    task automatic chk(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d t=%0t: got %h, expected %h", name, inst, $time, act, exp);
        end
    endtask
    function automatic logic [15:0] sel(input logic [15:0] a, input int nc);
        int off;
        off = int'(a % 16'd4);
        return ((a >> 2) == (16'h8008 >> 2) && off < nc) ? 16'(1 << off) : 16'h0;
    endfunction
    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int W  = WS[g];
        localparam int NC = NS[g];
        adrs_dec_mmio_if #(.NCH(NC)) bus ();
        assign bus.adrs    = adrs;
        assign bus.we      = we;
        assign bus.err_clr = err_clr;
        adrs_dec_mmio #(.BASE(16'h8008), .SPACE(2), .NCH(NC), .RD_WAIT(W)) dut (
            .cpu_clk(cpu_clk),
            .rst    (rst),
            .bus    (bus)
        );
        ev_t         q[$];
        int          ecnt = 0;
        int          pch  = 0;
        int          due  = 0;
        int          hold = -1;
        int          off  = 0;
        bit          pend = 1'b0;
        bit          req  = 1'b0;
        bit          exp_due;
        logic [15:0] s;
        logic [15:0] ewr  = '0;
        logic        ebad = 1'b0;
        // reference: a run of reads on one channel strobes once, W edges after it starts; an aborted wait costs one idle edge
        always begin
            @(posedge cpu_clk or negedge rst);
            if (!rst) begin
                q.delete();
                pend = 1'b0;
                hold = -1;
                ewr  = '0;
                ebad = 1'b0;
            end else begin
                ecnt++;
                s    = sel(adrs, NC);
                off  = int'(adrs % 16'd4);
                req  = s != 0 && !we;
                ebad = ((adrs >> 2) == (16'h8008 >> 2) && off >= NC) || (ebad && !err_clr);
                ewr  = we ? s : 16'h0;
                if (pend) begin
                    if (!req || off != pch) begin
                        pend = 1'b0;
                        hold = -1;
                    end else if (ecnt == due) begin
                        q.push_back(ev_t'{ecnt, 4'(s)});
                        pend = 1'b0;
                        hold = pch;
                    end
                end else if (!req) begin
                    hold = -1;
                end else if (off != hold) begin
                    if (W == 0) begin
                        q.push_back(ev_t'{ecnt, 4'(s)});
                        hold = off;
                    end else begin
                        pend = 1'b1;
                        pch  = off;
                        due  = ecnt + W;
                    end
                end
            end
        end
        // monitor: compare every output one step after each edge, popping strobes as they fall due
        always begin
            @(posedge cpu_clk);
            #1;
            chk("cs", g, 16'(bus.cs), sel(adrs, NC));
            chk("wr_stb", g, 16'(bus.wr_stb), ewr);
            chk("bad_adrs", g, 16'(bus.bad_adrs), 16'(ebad));
            exp_due = q.size() != 0 && q[0].cyc == ecnt;
            chk("rd_ack", g, 16'(bus.rd_ack), 16'(exp_due));
            chk("read_stb", g, 16'(bus.read_stb), exp_due ? 16'(q[0].stb) : 16'h0);
            if (exp_due) void'(q.pop_front());
        end
        // reset must clear registered outputs without waiting for a clock
        always begin
            @(negedge rst);
            #1;
            chk("rst_read_stb", g, 16'(bus.read_stb), 16'h0);
            chk("rst_rd_ack", g, 16'(bus.rd_ack), 16'h0);
            chk("rst_wr_stb", g, 16'(bus.wr_stb), 16'h0);
            chk("rst_bad_adrs", g, 16'(bus.bad_adrs), 16'h0);
        end
    end
    task automatic drive(input logic [15:0] a, input logic w, input logic c, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge cpu_clk);
            adrs    = a;
            we      = w;
            err_clr = c;
        end
    endtask
    initial begin
        #2 rst = 1'b0;
        #10;
        @(negedge cpu_clk) rst = 1'b1;
        drive(16'h0000, 0, 0, 2);
        drive(16'h8009, 0, 0, 3);
        drive(16'h0000, 0, 0, 6);
        drive(16'h800A, 0, 0, 6);
        drive(16'h0000, 0, 0, 3);
        drive(16'h800A, 0, 0, 2);
        drive(16'h800B, 0, 0, 8);
        drive(16'h0000, 0, 0, 6);
        drive(16'h8008, 0, 0, 1);
        drive(16'h800B, 0, 0, 1);
        drive(16'h0000, 0, 0, 6);
        drive(16'h800A, 1, 0, 2);
        drive(16'h0000, 0, 0, 2);
        drive(16'h800B, 1, 0, 1);
        drive(16'h0000, 0, 0, 2);
        drive(16'h0000, 0, 1, 1);
        drive(16'h0000, 0, 0, 1);
        drive(16'h800B, 0, 1, 1);
        drive(16'h0000, 0, 0, 2);
        drive(16'h0000, 0, 1, 1);
        drive(16'h800A, 0, 0, 3);
        @(posedge cpu_clk);
        #2 rst = 1'b0;
        #10;
        @(negedge cpu_clk) rst = 1'b1;
        drive(16'h800A, 0, 0, 8);
        drive(16'h9008, 0, 0, 4);
        drive(16'h9008, 1, 0, 2);
        drive(16'h0000, 0, 0, 4);
        drive(16'h8009, 0, 0, 3);
        drive(16'h8009, 1, 0, 2);
        drive(16'h0000, 0, 0, 4);
        for (int r = 0; r < 120; r++) begin
            logic [15:0] a;
            int          k;
            k = int'($urandom_range(0, 9));
            a = k < 6 ? 16'h8008 + 16'($urandom_range(0, 3)) :
                k < 8 ? 16'h9008 + 16'($urandom_range(0, 3)) : 16'($urandom);
            drive(a, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, int'($urandom_range(1, 8)));
        end
        drive(16'h0000, 0, 0, 12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
